// File: rtl/rx_fifo.sv
// Receive FIFO behind the UART receiver. It captures one entry per rising edge of done,
// reads out first-word-fall-through, and reports occupancy, a sticky overflow flag and a threshold flag.
module rx_fifo #(
  parameter int SIZE_DATA = 9,
  parameter int DEPTH     = 16,
  localparam int SIZE_ADDR = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_done_rx,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic                 i_error_frame,
  input  logic                 i_error_parity,
  input  logic                 i_error_overun,
  input  logic                 i_rd_en,
  input  logic [SIZE_ADDR:0]   i_threshold,
  input  logic                 i_ovf_clr,
  output logic [SIZE_DATA-1:0] o_data,
  output logic                 o_error_frame,
  output logic                 o_error_parity,
  output logic                 o_error_overun,
  output logic                 o_empty,
  output logic                 o_full,
  output logic [SIZE_ADDR:0]   o_count,
  output logic                 o_overflow,
  output logic                 o_thresh
);

  localparam int ENTRY_W = SIZE_DATA + 3;
  localparam logic [SIZE_ADDR:0] FULL_CNT = (SIZE_ADDR+1)'(DEPTH);

  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [SIZE_ADDR-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SIZE_ADDR:0]   count_q, count_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic                 wr, rd, empty, full, mem_we;
  logic [ENTRY_W-1:0]   head;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign wr    = i_done_rx & ~done_q;
  assign rd    = i_rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    done_d   = i_done_rx;
    ovf_d    = ovf_q;
    mem_we   = 1'b0;
    if (i_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      done_d   = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      // A pop in the same cycle frees a slot, so a write on full proceeds
      mem_we = wr & (~full | rd);
      if (mem_we) wr_ptr_d = wr_ptr_q + SIZE_ADDR'(1);
      if (rd)     rd_ptr_d = rd_ptr_q + SIZE_ADDR'(1);
      count_d = count_q + (SIZE_ADDR+1)'(mem_we) - (SIZE_ADDR+1)'(rd);
      if (wr & full & ~rd) ovf_d = 1'b1;
      else if (i_ovf_clr)  ovf_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; contents are only exposed while count is non-zero
  always_ff @(posedge i_clk) begin
    if (!i_rst && mem_we)
      mem[wr_ptr_q] <= {i_error_overun, i_error_parity, i_error_frame, i_data};
  end

  assign head = empty ? '0 : mem[rd_ptr_q];
  assign {o_error_overun, o_error_parity, o_error_frame, o_data} = head;
  assign o_empty    = empty;
  assign o_full     = full;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;
  assign o_thresh   = (i_threshold != '0) && (count_q >= i_threshold);

endmodule
